cache_base_ctrl: RTL and testbench

Control FSM for the direct-mapped, write-back, write-allocate base cache: 32 lines × 16 words. It sits beside the cache datapath and drives every datapath enable, select and bit-set signal. It handles the val/rdy handshakes on the processor side and the memory side, and it sequences tag check, hit access, dirty-line eviction, line refill and whole-cache flush. It holds no address or data state; the processor request message stays on the datapath inputs for the whole transaction.

---
 rtl/lab3_cache_pkg.sv | 39 +++
 rtl/cache_base_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cache_base_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_cache_pkg.sv
// Shared geometry, memory-request type codes and controller state encoding.
// The FLUSH_* states exist only when CACHE_FLUSH_EN is defined.
package lab3_cache_pkg;

    localparam int unsigned NUM_LINES = 32;
    localparam int unsigned NUM_WORDS = 16;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;

`ifdef CACHE_FLUSH_EN
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_TAG         = 4'd1,
        ST_WR_HIT      = 4'd2,
        ST_RESP        = 4'd3,
        ST_EVICT_REQ   = 4'd4,
        ST_EVICT_RESP  = 4'd5,
        ST_REFILL_REQ  = 4'd6,
        ST_REFILL_RESP = 4'd7,
        ST_FLUSH_SCAN  = 4'd8,
        ST_FLUSH_REQ   = 4'd9,
        ST_FLUSH_RESP  = 4'd10,
        ST_FLUSH_DONE  = 4'd11
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_TAG         = 4'd1,
        ST_WR_HIT      = 4'd2,
        ST_RESP        = 4'd3,
        ST_EVICT_REQ   = 4'd4,
        ST_EVICT_RESP  = 4'd5,
        ST_REFILL_REQ  = 4'd6,
        ST_REFILL_RESP = 4'd7
    } state_t;
`endif

endpackage

// File: rtl/cache_base_ctrl.sv
// Control FSM for the direct-mapped write-back base cache (32 lines x 16 words).
// Optional whole-cache flush sequencing is enabled by defining CACHE_FLUSH_EN.
module cache_base_ctrl
    import lab3_cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       memreq_val,
    output logic       memreq_rdy,
    input  logic [2:0] memreq_type,
    output logic       memresp_val,
    input  logic       memresp_rdy,
    output logic       cache_req_val,
    input  logic       cache_req_rdy,
    input  logic       cache_resp_val,
    output logic       cache_resp_rdy,
    input  logic       flush,
    input  logic       all_flushed,
    output logic       flush_done,
    output logic       get_next_flush_line,
    input  logic       tarray_match,
    input  logic       line_dirty,
    input  logic       line_valid,
    input  logic       count_done,
    output logic       tarray_en,
    output logic       tarray_wen,
    output logic       darray_en,
    output logic       darray_wen,
    output logic       count_en,
    output logic       count_reset,
    output logic       write_data_sel,
    output logic       index_sel,
    output logic       write_word_sel,
    output logic       read_word_sel,
    output logic [2:0] mem_action,
    output logic       clean_set,
    output logic       dirty_set,
    output logic       valid_set
);

    state_t state_q, state_d;
    logic   is_write, hit;

    assign is_write = (memreq_type == MEM_WRITE);
    assign hit      = tarray_match && line_valid;

`ifndef CACHE_FLUSH_EN
    logic unused_flush_inputs;
    assign unused_flush_inputs = flush | all_flushed;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef CACHE_FLUSH_EN
                if (flush)           state_d = ST_FLUSH_SCAN;
                else if (memreq_val) state_d = ST_TAG;
`else
                if (memreq_val)      state_d = ST_TAG;
`endif
            end
            ST_TAG: begin
                if (hit)                          state_d = is_write ? ST_WR_HIT : ST_RESP;
                else if (line_valid && line_dirty) state_d = ST_EVICT_REQ;
                else                              state_d = ST_REFILL_REQ;
            end
            ST_WR_HIT:      state_d = ST_RESP;
            ST_RESP:        if (memresp_rdy)   state_d = ST_IDLE;
            ST_EVICT_REQ:   if (cache_req_rdy) state_d = ST_EVICT_RESP;
            ST_EVICT_RESP:  if (cache_resp_val) state_d = count_done ? ST_REFILL_REQ : ST_EVICT_REQ;
            ST_REFILL_REQ:  if (cache_req_rdy) state_d = ST_REFILL_RESP;
            // The final refill word returns to TAG so the re-check takes the normal hit path.
            ST_REFILL_RESP: if (cache_resp_val) state_d = count_done ? ST_TAG : ST_REFILL_REQ;
`ifdef CACHE_FLUSH_EN
            ST_FLUSH_SCAN:  state_d = all_flushed ? ST_FLUSH_DONE : ST_FLUSH_REQ;
            ST_FLUSH_REQ:   if (cache_req_rdy) state_d = ST_FLUSH_RESP;
            ST_FLUSH_RESP:  if (cache_resp_val) state_d = count_done ? ST_FLUSH_SCAN : ST_FLUSH_REQ;
            ST_FLUSH_DONE:  state_d = ST_IDLE;
`endif
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        memreq_rdy          = 1'b0;
        memresp_val         = 1'b0;
        cache_req_val       = 1'b0;
        cache_resp_rdy      = 1'b0;
        flush_done          = 1'b0;
        get_next_flush_line = 1'b0;
        tarray_en           = 1'b0;
        tarray_wen          = 1'b0;
        darray_en           = 1'b0;
        darray_wen          = 1'b0;
        count_en            = 1'b0;
        count_reset         = 1'b0;
        write_data_sel      = 1'b0;
        index_sel           = 1'b0;
        write_word_sel      = 1'b0;
        read_word_sel       = 1'b0;
        mem_action          = MEM_READ;
        clean_set           = 1'b0;
        dirty_set           = 1'b0;
        valid_set           = 1'b0;
        case (state_q)
            ST_IDLE: count_reset = 1'b1;
            ST_TAG: begin
                tarray_en   = 1'b1;
                count_reset = 1'b1;
            end
            ST_WR_HIT: begin
                darray_en  = 1'b1;
                darray_wen = 1'b1;
                dirty_set  = 1'b1;
            end
            ST_RESP: begin
                memresp_val = 1'b1;
                memreq_rdy  = memresp_rdy;
                darray_en   = !is_write;
            end
            ST_EVICT_REQ: begin
                cache_req_val = 1'b1;
                mem_action    = MEM_WRITE;
                darray_en     = 1'b1;
                read_word_sel = 1'b1;
            end
            ST_EVICT_RESP: begin
                cache_resp_rdy = 1'b1;
                if (cache_resp_val) begin
                    count_reset = count_done;
                    count_en    = !count_done;
                end
            end
            ST_REFILL_REQ: begin
                cache_req_val = 1'b1;
                mem_action    = MEM_READ;
            end
            ST_REFILL_RESP: begin
                cache_resp_rdy = 1'b1;
                if (cache_resp_val) begin
                    darray_en      = 1'b1;
                    darray_wen     = 1'b1;
                    write_data_sel = 1'b1;
                    write_word_sel = 1'b1;
                    tarray_en      = count_done;
                    tarray_wen     = count_done;
                    valid_set      = count_done;
                    clean_set      = count_done;
                    count_en       = !count_done;
                end
            end
`ifdef CACHE_FLUSH_EN
            ST_FLUSH_SCAN: get_next_flush_line = 1'b1;
            ST_FLUSH_REQ: begin
                cache_req_val       = 1'b1;
                mem_action          = MEM_WRITE;
                darray_en           = 1'b1;
                read_word_sel       = 1'b1;
                index_sel           = 1'b1;
                get_next_flush_line = 1'b1;
            end
            ST_FLUSH_RESP: begin
                cache_resp_rdy      = 1'b1;
                index_sel           = 1'b1;
                get_next_flush_line = 1'b1;
                if (cache_resp_val) begin
                    count_reset = count_done;
                    clean_set   = count_done;
                    count_en    = !count_done;
                end
            end
            ST_FLUSH_DONE: flush_done = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_base_ctrl.sv
// Bench for cache_base_ctrl: emulates the datapath arrays and a zero-wait memory,
// and compares transaction latency, memory traffic and line status against a cache model.
module tb_cache_base_ctrl;
    import lab3_cache_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       memreq_val, memreq_rdy;
    logic [2:0] memreq_type;
    logic       memresp_val, memresp_rdy;
    logic       cache_req_val, cache_req_rdy;
    logic       cache_resp_val, cache_resp_rdy;
    logic       flush, all_flushed, flush_done, get_next_flush_line;
    logic       tarray_match, line_dirty, line_valid, count_done;
    logic       tarray_en, tarray_wen, darray_en, darray_wen;
    logic       count_en, count_reset;
    logic       write_data_sel, index_sel, write_word_sel, read_word_sel;
    logic [2:0] mem_action;
    logic       clean_set, dirty_set, valid_set;

    cache_base_ctrl dut (
        .clk(clk), .reset(reset),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy),
        .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy),
        .flush(flush), .all_flushed(all_flushed), .flush_done(flush_done),
        .get_next_flush_line(get_next_flush_line),
        .tarray_match(tarray_match), .line_dirty(line_dirty), .line_valid(line_valid),
        .count_done(count_done),
        .tarray_en(tarray_en), .tarray_wen(tarray_wen),
        .darray_en(darray_en), .darray_wen(darray_wen),
        .count_en(count_en), .count_reset(count_reset),
        .write_data_sel(write_data_sel), .index_sel(index_sel),
        .write_word_sel(write_word_sel), .read_word_sel(read_word_sel),
        .mem_action(mem_action),
        .clean_set(clean_set), .dirty_set(dirty_set), .valid_set(valid_set)
    );

    always #5 clk = ~clk;

    // Datapath emulation: status arrays and word counter driven by the controller's outputs.
    logic [4:0]  req_idx;
    logic [20:0] req_tag;
    logic [31:0] dp_valid, dp_dirty;
    logic [20:0] dp_tag [32];
    logic [3:0]  cnt;
    logic [4:0]  flush_idx, cur_idx;
    logic        dp_clear;

    always_comb begin
        flush_idx = '0;
        for (int i = 31; i >= 0; i--)
            if (dp_dirty[i]) flush_idx = i[4:0];
    end

    assign cur_idx      = index_sel ? flush_idx : req_idx;
    assign tarray_match = (dp_tag[cur_idx] == req_tag);
    assign line_valid   = dp_valid[cur_idx];
    assign line_dirty   = dp_dirty[cur_idx];
    assign count_done   = (cnt == 4'd15);
    assign all_flushed  = (dp_dirty == '0);

    always @(posedge clk) begin
        if (dp_clear) begin
            dp_valid <= '0;
            dp_dirty <= '0;
            cnt      <= '0;
            for (int i = 0; i < 32; i++) dp_tag[i] <= '0;
        end else begin
            if (count_reset)    cnt <= '0;
            else if (count_en)  cnt <= cnt + 4'd1;
            if (tarray_en && tarray_wen) dp_tag[cur_idx] <= req_tag;
            if (valid_set) dp_valid[cur_idx] <= 1'b1;
            if (dirty_set) dp_dirty[cur_idx] <= 1'b1;
            if (clean_set) dp_dirty[cur_idx] <= 1'b0;
        end
    end

    // Memory traffic monitor: every request that fires at the next edge is logged.
    typedef struct { logic [2:0] act; int word; int idx; } mreq_t;
    mreq_t log_q[$];
    int    fd_cnt;
    int    flushsig_cnt;

    always @(negedge clk) begin
        if (cache_req_val && cache_req_rdy)
            log_q.push_back('{mem_action, int'(cnt), int'(cur_idx)});
        if (flush_done) fd_cnt++;
        if (get_next_flush_line || index_sel) flushsig_cnt++;
    end

    // Reference cache model (write-back, write-allocate, direct-mapped).
    bit        ref_valid [32];
    bit        ref_dirty [32];
    bit [20:0] ref_tag   [32];

    task automatic predict(input bit wr, input int idx, input bit [20:0] tag,
                           output int lat, output int nwr, output int nrd);
        bit h;
        h   = ref_valid[idx] && (ref_tag[idx] == tag);
        nwr = (!h && ref_valid[idx] && ref_dirty[idx]) ? 16 : 0;
        nrd = h ? 0 : 16;
        lat = 2 + int'(wr) + (h ? 0 : 1) + 2 * nwr + 2 * nrd;
        if (!h) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) ref_dirty[idx] = 1'b1;
    endtask

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_line(input int idx);
        check("line_valid", dp_valid[idx], ref_valid[idx]);
        check("line_dirty", dp_dirty[idx], ref_dirty[idx]);
        if (ref_valid[idx]) check("line_tag", dp_tag[idx], ref_tag[idx]);
    endtask

    function automatic logic [18:0] others_vec();
        return {memreq_rdy, memresp_val, cache_req_val, cache_resp_rdy, flush_done,
                get_next_flush_line, tarray_en, tarray_wen, darray_en, darray_wen,
                count_en, write_data_sel, index_sel, write_word_sel, read_word_sel,
                clean_set, dirty_set, valid_set, |mem_action};
    endfunction

    task automatic do_req(input bit wr, input logic [31:0] addr, input int exp_lat,
                          input int exp_wr, input int exp_rd, input bit stall);
        int cyc, nwr, nrd, bad;
        bit got;
        @(posedge clk); #1;
        req_idx     = addr[10:6];
        req_tag     = addr[31:11];
        memreq_type = wr ? MEM_WRITE : MEM_READ;
        memreq_val  = 1'b1;
        memresp_rdy = 1'b1;
        log_q.delete();
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk); cyc++; #1;
            // Word 3 of a clean refill is requested 8 cycles in; hold it off for 5 cycles.
            cache_req_rdy = !(stall && cyc >= 8 && cyc < 13);
            @(negedge clk);
            if (!cache_req_rdy) begin
                check("stall_req_val", cache_req_val, 1);
                check("stall_count_en", count_en, 0);
                check("stall_action", mem_action, MEM_READ);
            end
            if (memresp_val) got = 1'b1;
        end
        check("resp_seen", got, 1);
        check("resp_latency", cyc, exp_lat);
        check("req_rdy_with_resp", memreq_rdy, 1);
        nwr = 0; nrd = 0; bad = 0;
        foreach (log_q[i]) begin
            if (log_q[i].act == MEM_WRITE) begin
                if (nrd != 0 || log_q[i].word != nwr % 16 || log_q[i].idx != int'(req_idx)) bad++;
                nwr++;
            end else if (log_q[i].act == MEM_READ) begin
                if (log_q[i].word != nrd % 16 || log_q[i].idx != int'(req_idx)) bad++;
                nrd++;
            end else bad++;
        end
        check("evict_writes", nwr, exp_wr);
        check("refill_reads", nrd, exp_rd);
        check("req_sequence_errors", bad, 0);
        @(posedge clk); #1;
        memreq_val    = 1'b0;
        cache_req_rdy = 1'b1;
    endtask

    typedef struct { bit wr; logic [31:0] addr; int lat; int nwr; int nrd; } vec_t;
    vec_t vecs [7];

    initial begin
        int lat, nw, nr, cyc, bad;
        logic [31:0] a;

        vecs[0] = '{1'b0, 32'h0000_1000, 35,  0, 16};
        vecs[1] = '{1'b0, 32'h0000_1000,  2,  0,  0};
        vecs[2] = '{1'b1, 32'h0000_1004,  3,  0,  0};
        vecs[3] = '{1'b0, 32'h0000_1804, 67, 16, 16};
        vecs[4] = '{1'b1, 32'h0000_10C0, 36,  0, 16};
        vecs[5] = '{1'b1, 32'h0000_11C0, 36,  0, 16};
        vecs[6] = '{1'b0, 32'h0000_10C4,  2,  0,  0};

        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = '0;
        end
        fd_cnt = 0; flushsig_cnt = 0;
        reset = 1'b0; dp_clear = 1'b1;
        memreq_val = 1'b0; memreq_type = MEM_READ; memresp_rdy = 1'b1;
        cache_req_rdy = 1'b1; cache_resp_val = 1'b1; flush = 1'b0;
        req_idx = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_count_reset", count_reset, 1);
        check("reset_other_outputs", others_vec(), 0);
        @(posedge clk); #1;
        reset = 1'b1; dp_clear = 1'b0;

        foreach (vecs[i]) begin
            predict(vecs[i].wr, int'(vecs[i].addr[10:6]), vecs[i].addr[31:11], lat, nw, nr);
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].lat, vecs[i].nwr, vecs[i].nrd, 1'b0);
            check_line(int'(vecs[i].addr[10:6]));
        end

        // Refill with a 5-cycle memory stall on word 3 (line 9, cold).
        a = 32'h0000_1240;
        predict(1'b0, 9, a[31:11], lat, nw, nr);
        do_req(1'b0, a, lat + 5, nw, nr, 1'b1);
        check_line(9);

`ifdef CACHE_FLUSH_EN
        log_q.delete(); fd_cnt = 0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        cyc = 0;
        while (fd_cnt == 0 && cyc < 300) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        check("flush_done_pulses", fd_cnt, 1);
        check("flush_writes", log_q.size(), 32);
        bad = 0;
        foreach (log_q[i])
            if (log_q[i].act != MEM_WRITE || log_q[i].word != i % 16 ||
                log_q[i].idx != ((i < 16) ? 3 : 7)) bad++;
        check("flush_sequence_errors", bad, 0);
        check("flush_all_clean", dp_dirty, 0);
        for (int i = 0; i < 32; i++) ref_dirty[i] = 1'b0;

        log_q.delete(); fd_cnt = 0;
        @(posedge clk); #1 flush = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); cyc++; #1;
            if (cyc == 1) flush = 1'b0;
            @(negedge clk);
            if (flush_done) break;
        end
        check("clean_flush_latency", cyc, 2);
        repeat (3) @(negedge clk);
        check("clean_flush_pulses", fd_cnt, 1);
        check("clean_flush_no_req", log_q.size(), 0);
`else
        log_q.delete(); fd_cnt = 0; flushsig_cnt = 0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (6) @(negedge clk);
        check("flush_ignored_done", fd_cnt, 0);
        check("flush_ignored_signals", flushsig_cnt, 0);
        check("flush_ignored_no_req", log_q.size(), 0);
        check("flush_ignored_idle", count_reset, 1);
`endif

        for (int n = 0; n < 30; n++) begin
            bit          wr;
            int          idx;
            logic [20:0] tg;
            wr  = 1'($urandom_range(1, 0));
            idx = int'($urandom_range(3, 0));
            tg  = 21'($urandom_range(3, 1));
            a   = {tg, 5'(idx), 6'($urandom_range(15, 0) << 2)};
            predict(wr, idx, tg, lat, nw, nr);
            do_req(wr, a, lat, nw, nr, 1'b0);
            check_line(idx);
        end

        // Reset abandons a dirty-miss transaction during its second eviction response.
        a = {21'd1, 5'd20, 6'd0};
        predict(1'b1, 20, 21'd1, lat, nw, nr);
        do_req(1'b1, a, lat, nw, nr, 1'b0);
        a = {21'd2, 5'd20, 6'd0};
        @(posedge clk); #1;
        req_idx = 5'd20; req_tag = 21'd2; memreq_type = MEM_READ; memreq_val = 1'b1;
        cyc = 0;
        while (cyc < 5) begin @(posedge clk); cyc++; end
        @(negedge clk);
        check("evict_resp_rdy", cache_resp_rdy, 1);
        reset = 1'b0; memreq_val = 1'b0;
        @(negedge clk);
        check("midreset_count_reset", count_reset, 1);
        check("midreset_other_outputs", others_vec(), 0);
        @(posedge clk); #1 reset = 1'b1;
        log_q.delete();
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (memresp_val || cache_req_val) bad++;
        end
        check("midreset_quiet", bad, 0);
        check_line(20);
        predict(1'b0, 20, 21'd2, lat, nw, nr);
        do_req(1'b0, a, lat, nw, nr, 1'b0);
        check_line(20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
